i2s_rx_frontend: RTL
====================

// Module: i2s_rx_frontend
// PURPOSE
//  I2S master receiver feeding the DSP subsystem. Generates bclk/lrck for the audio ADC,
//  deserialises 16-bit two's-complement left/right samples, and provides input_sample plus
//  a sample_clock strobe for the filter/echo/bypass stages. One clock domain; adc_data is async.
// PARAMETERS
//  CLK_DIV     8   system clocks per bclk half-period (legal >= 4); bclk = clock/(2*CLK_DIV)
//  SLOT_BITS   32  bclk periods per channel slot (legal 17..64); frame = 2*SLOT_BITS bclks
//  SAMPLE_BITS 16  data bits captured per slot, MSB first
// PORTS
//  clock         in   1   system clock
//  reset         in   1   asynchronous, active-low reset
//  enable        in   1   1 = run bclk/lrck and capture; 0 = stop at next frame boundary
//  adc_data      in   1   serial data from ADC; async, 2-flop synchronised internally
//  bclk          out  1   bit clock to ADC
//  lrck          out  1   word select; 0 = left slot, 1 = right slot
//  left_sample   out  16  last complete left sample
//  input_sample  out  16  last complete right sample (or mono mix, see CONFIGURATION)
//  sample_valid  out  1   one-clock pulse: left_sample/input_sample just updated
//  sample_clock  out  1   frame-rate clock for DSP subsystem
// BEHAVIOUR
//  - Reset (reset=0, async): bclk=0, lrck=0, sample_clock=0, sample_valid=0, samples=0,
//    div/bit counters=0, synchroniser=0, state IDLE. Reset mid-frame discards the partial word.
//  - States: IDLE -> LEFT (enable=1 seen in IDLE); LEFT -> RIGHT at end of left slot;
//    RIGHT -> LEFT at end of right slot if enable=1, else -> IDLE. In IDLE bclk/lrck held 0.
//  - Divider 0..CLK_DIV-1; at terminal count bclk toggles. rise_tick = cycle bclk goes 0->1,
//    fall_tick = cycle bclk goes 1->0.
//  - Bit counter 0..SLOT_BITS-1 advances on each fall_tick; wrap ends the slot; lrck toggles
//    on that same fall_tick (lrck changes only while bclk falls).
//  - I2S timing: bit 0 of each slot is the delay bit (ignored); bits 1..SAMPLE_BITS are
//    sampled from synchronised adc_data on rise_tick and shifted in MSB first; rest ignored.
//  - Left word latched to left_sample at rise_tick of right-slot bit SAMPLE_BITS, together
//    with right word to input_sample; sample_valid=1 for exactly that cycle. Both outputs
//    change atomically once per frame; never on a partial frame.
//  - sample_clock rises the clock after sample_valid, stays high SLOT_BITS*CLK_DIV clocks,
//    then low; so downstream posedge always sees settled data. Held 0 in IDLE.
//  - Latency: last right bit on adc_data -> sample_valid = 2 sync clocks + <=1 clock.
//  - enable deasserted mid-frame: current frame completes (incl. its sample_valid), then IDLE
//    at next left-slot boundary with bclk=0, lrck=0. Re-enable starts a fresh left slot.
//  - enable toggled within a frame without reaching boundary: no effect.
//  - No arithmetic except mono mix; samples passed bit-exact.
// CONFIGURATION
//  I2S_RX_MONO_MIX_EN defined: input_sample = (left + right) >>> 1, 17-bit signed sum,
//    arithmetic shift, no saturation needed; left_sample unchanged.
//  Not defined: input_sample = right word verbatim.
// TESTING
//  1 reset low with enable=1 -> all outputs 0, bclk static; release -> first bclk rise after
//    CLK_DIV clocks, bclk period 16 clocks, lrck period 1024 clocks (defaults).
//  2 ADC model sends L=16'h1234, R=16'hABCD (I2S, driven on bclk fall) -> one sample_valid,
//    left_sample=16'h1234, input_sample=16'hABCD; sample_clock rises next clock.
//  3 L=16'h8000, R=16'h7FFF then L=R=16'hFFFF -> exact words, one pulse per frame, none extra.
//  4 enable=0 at mid left slot -> frame finishes, one sample_valid, then bclk=lrck=0 held;
//    enable=1 -> restart in left slot, next frame captured correctly.
//  5 reset asserted mid right slot -> immediate zeros, no sample_valid; next full frame ok.
//  6 I2S_RX_MONO_MIX_EN: L=16'h0100, R=16'h0300 -> input_sample=16'h0200;
//    L=16'h8000, R=16'h8000 -> 16'h8000; L=16'h7FFF, R=16'h8001 -> 16'h0000.

Source files
------------

// File: rtl/i2s_rx_frontend_if.sv
// Pin/sample bundle for the I2S receive front end.
// master = the front end itself; slave = the ADC/DSP side.
interface i2s_rx_frontend_if #(
  parameter int SAMPLE_BITS = 16
);
  logic                   enable;
  logic                   adc_data;
  logic                   bclk;
  logic                   lrck;
  logic [SAMPLE_BITS-1:0] left_sample;
  logic [SAMPLE_BITS-1:0] input_sample;
  logic                   sample_valid;
  logic                   sample_clock;

  modport master (
    input  enable, adc_data,
    output bclk, lrck, left_sample, input_sample, sample_valid, sample_clock
  );

  modport slave (
    output enable, adc_data,
    input  bclk, lrck, left_sample, input_sample, sample_valid, sample_clock
  );
endinterface

// File: rtl/i2s_rx_frontend.sv
// I2S master receiver: generates bclk/lrck, deserialises left/right words, strobes the DSP.
// Optional `I2S_RX_MONO_MIX_EN: input_sample carries (left + right) >>> 1 instead of right.
module i2s_rx_frontend #(
  parameter int CLK_DIV     = 8,
  parameter int SLOT_BITS   = 32,
  parameter int SAMPLE_BITS = 16
) (
  input  logic              clock,
  input  logic              reset,
  i2s_rx_frontend_if.master bus
);
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int BIT_W  = $clog2(SLOT_BITS);
  localparam int SC_LEN = SLOT_BITS * CLK_DIV;
  localparam int SC_W   = $clog2(SC_LEN);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

  typedef struct packed {
    logic [SAMPLE_BITS-1:0] left;
    logic [SAMPLE_BITS-1:0] right;
  } frame_t;

  state_t                 state_q, state_d;
  logic [DIV_W-1:0]       div_q;
  logic [BIT_W-1:0]       bit_q;
  logic                   bclk_q, lrck_q;
  logic [1:0]             sync_q;
  frame_t                 shift_q;
  logic [SAMPLE_BITS-1:0] left_q, out_q;
  logic                   valid_q, sclk_q;
  logic [SC_W-1:0]        sc_cnt_q;

  logic data_s, running, tc, rise_tick, fall_tick, slot_end, capture, latch;
  logic [SAMPLE_BITS-1:0] right_full;

  assign data_s    = sync_q[1];
  // The divider starts in the IDLE cycle that sees enable, so the first rise lands CLK_DIV clocks later.
  assign running   = (state_q != IDLE) || bus.enable;
  assign tc        = running && (div_q == DIV_W'(CLK_DIV - 1));
  assign rise_tick = tc && !bclk_q;
  assign fall_tick = tc && bclk_q;
  assign slot_end  = fall_tick && (bit_q == BIT_W'(SLOT_BITS - 1));
  assign capture   = rise_tick && (state_q != IDLE) && (bit_q != '0) &&
                     (bit_q <= BIT_W'(SAMPLE_BITS));
  assign latch     = capture && (state_q == RIGHT) && (bit_q == BIT_W'(SAMPLE_BITS));
  assign right_full = {shift_q.right[SAMPLE_BITS-2:0], data_s};

  function automatic logic [SAMPLE_BITS-1:0] mix(input logic [SAMPLE_BITS-1:0] l,
                                                 input logic [SAMPLE_BITS-1:0] r);
`ifdef I2S_RX_MONO_MIX_EN
    logic signed [SAMPLE_BITS:0] sum;
    sum = $signed({l[SAMPLE_BITS-1], l}) + $signed({r[SAMPLE_BITS-1], r});
    return sum[SAMPLE_BITS:1];
`else
    logic [SAMPLE_BITS-1:0] unused_l;
    unused_l = l;
    return r;
`endif
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.enable) state_d = LEFT;
      LEFT:    if (slot_end)   state_d = RIGHT;
      RIGHT:   if (slot_end)   state_d = bus.enable ? LEFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bit clock, word select and slot position.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
      bit_q  <= '0;
      lrck_q <= 1'b0;
    end else begin
      if (!running || tc) div_q <= '0;
      else                div_q <= div_q + 1'b1;
      if (tc) bclk_q <= ~bclk_q;
      if (fall_tick) bit_q <= slot_end ? '0 : bit_q + 1'b1;
      if (slot_end)  lrck_q <= (state_d == RIGHT);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[0], bus.adc_data};
  end

  // Deserialise, then publish both channels together once the last right bit arrives.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      left_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= latch;
      if (capture) begin
        if (state_q == LEFT) shift_q.left  <= {shift_q.left[SAMPLE_BITS-2:0], data_s};
        else                 shift_q.right <= right_full;
      end
      if (latch) begin
        left_q <= shift_q.left;
        out_q  <= mix(shift_q.left, right_full);
      end
    end
  end

  // Frame-rate strobe: rises the clock after sample_valid, high for one slot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sclk_q   <= 1'b0;
      sc_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      sclk_q   <= 1'b0;
      sc_cnt_q <= '0;
    end else if (valid_q) begin
      sclk_q   <= 1'b1;
      sc_cnt_q <= SC_W'(SC_LEN - 1);
    end else if (sclk_q) begin
      if (sc_cnt_q == '0) sclk_q <= 1'b0;
      else                sc_cnt_q <= sc_cnt_q - 1'b1;
    end
  end

  assign bus.bclk         = bclk_q;
  assign bus.lrck         = lrck_q;
  assign bus.left_sample  = left_q;
  assign bus.input_sample = out_q;
  assign bus.sample_valid = valid_q;
  assign bus.sample_clock = sclk_q;
endmodule
